// File: rtl/tdc_readout_pkg.sv
// Shared types and constants for the TDC readout arbiter.
package tdc_readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  localparam int         OUT_W      = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_readout_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting channel at or above ptr, with wrap.
module tdc_rr_pick
  import tdc_readout_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic           any,
  output logic [3:0]     idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_ch;

  // Scan from the far end back toward ptr so the closest request is the last one written.
  always_comb begin
    any   = 1'b0;
    idx   = 4'd0;
    w_sum = '0;
    w_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (PW + 1)'(i);
      if (w_sum >= (PW + 1)'(NCH)) w_sum = w_sum - (PW + 1)'(NCH);
      w_ch = w_sum[PW-1:0];
      if (req[w_ch]) begin
        any = 1'b1;
        idx = 4'(w_ch);
      end
    end
  end

endmodule

// File: rtl/tdc_readout_arbiter.sv
// Round-robin, burst-limited readout of NCH timegen hit FIFOs onto one tagged 16-bit stream.
module tdc_readout_arbiter
  import tdc_readout_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    ch_enable,
  input  logic [NCH-1:0]    fifo_data_available,
  output logic [NCH-1:0]    read_fifo,
  input  logic [NCH*DW-1:0] fifo_dout,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       word_count
);

  localparam int         PW      = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [7:0] BURST_W = 8'(BURST);

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [3:0]         r_grant;
  logic [7:0]         r_burst;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_valid;
  logic [15:0]        r_word_count;

  logic [NCH-1:0]     w_req;
  logic               w_any;
  logic [3:0]         w_idx;
  logic [PW-1:0]      w_gsel;
  logic [PW-1:0]      w_ptr_nxt;
  logic [7:0]         w_burst_nxt;
  logic               w_more;
  logic [DW-1:0]      w_dout [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_dout
    assign w_dout[g] = fifo_dout[g*DW +: DW];
  end

  assign w_req       = fifo_data_available & ch_enable;
  assign w_gsel      = r_grant[PW-1:0];
  assign w_ptr_nxt   = (w_gsel == PW'(NCH - 1)) ? '0 : w_gsel + 1'b1;
  assign w_burst_nxt = r_burst + 8'd1;
  assign w_more      = (w_burst_nxt < BURST_W) && fifo_data_available[w_gsel] && ch_enable[w_gsel];

  tdc_rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Strobe decoded from the registered state so it is clean for exactly the READ cycle.
  always_comb begin
    read_fifo = '0;
    if (r_state == READ) read_fifo[w_gsel] = 1'b1;
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_grant      <= 4'd0;
      r_burst      <= 8'd0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_idx;
            r_state <= READ;
          end
        end
        READ: r_state <= WAIT;
        WAIT: begin
          // FIFO is not first-word-fall-through: dout is valid one cycle after the strobe.
          r_out_data  <= {HDR_NIBBLE, r_grant, w_dout[w_gsel]};
          r_out_valid <= 1'b1;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_word_count <= r_word_count + 16'd1;
            if (w_more) begin
              r_burst <= w_burst_nxt;
              r_state <= READ;
            end else begin
              r_ptr   <= w_ptr_nxt;
              r_burst <= 8'd0;
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != IDLE);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed and randomized bench for tdc_readout_arbiter against a transaction-level scheduling model.
module tb_tdc_readout_arbiter;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic              SYSCLK = 1'b0;
  logic              RESET  = 1'b1;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    fifo_data_available;
  logic [NCH-1:0]    read_fifo;
  logic [NCH*DW-1:0] fifo_dout;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [15:0]       word_count;

  tdc_readout_arbiter #(.NCH(NCH), .DW(DW), .BURST(BURST)) dut (
    .SYSCLK              (SYSCLK),
    .RESET               (RESET),
    .ch_enable           (ch_enable),
    .fifo_data_available (fifo_data_available),
    .read_fifo           (read_fifo),
    .fifo_dout           (fifo_dout),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .busy                (busy),
    .word_count          (word_count)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Standard (non-FWFT) FIFO model per channel: push from the stimulus, pop on read strobe.
  logic [7:0] mem [NCH][256];
  int         push_cnt [NCH] = '{default: 0};
  int         pop_cnt  [NCH] = '{default: 0};
  logic [7:0] dout_r   [NCH] = '{default: 8'h00};

  always @(posedge SYSCLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (read_fifo[i] && (push_cnt[i] != pop_cnt[i])) begin
        dout_r[i]  <= mem[i][8'(pop_cnt[i])];
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  always_comb begin
    fifo_dout           = '0;
    fifo_data_available = '0;
    for (int i = 0; i < NCH; i++) begin
      fifo_dout[i*DW +: DW]  = dout_r[i];
      fifo_data_available[i] = (push_cnt[i] != pop_cnt[i]);
    end
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          viol = 0;
  int          cyc_n = 0;
  int          fv_cyc = -1;
  int          rd_n [NCH] = '{default: 0};
  int          rd_cyc [$];
  logic [15:0] got [$];
  logic [15:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;
  int          model_ptr = 0;
  int          model_wc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    mem[ch][8'(push_cnt[ch])] = d;
    push_cnt[ch] = push_cnt[ch] + 1;
  endtask

  // One clock: drive out_ready at the falling edge, then observe the settled outputs.
  task automatic cyc(input int mode);
    @(negedge SYSCLK);
    cyc_n++;
    out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    #1;
    if (prev_stall && !(out_valid && out_data == prev_data)) viol++;
    if ((read_fifo & (read_fifo - 1'b1)) != '0) viol++;
    if ((read_fifo & ~fifo_data_available) != '0) viol++;
    if ((read_fifo & ~ch_enable) != '0) viol++;
    if (read_fifo != '0) rd_cyc.push_back(cyc_n);
    for (int i = 0; i < NCH; i++) if (read_fifo[i]) rd_n[i]++;
    if (out_valid && fv_cyc < 0) fv_cyc = cyc_n;
    if (out_valid && out_ready) got.push_back(out_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  // Scheduling rule: from the pointer, first enabled non-empty channel gets up to BURST words,
  // then the pointer moves past it. Valid while FIFO contents and mask stay fixed.
  task automatic build_expect();
    int head [NCH];
    int found;
    int c;
    int n;
    exp_q.delete();
    got.delete();
    for (int i = 0; i < NCH; i++) head[i] = pop_cnt[i];
    forever begin
      found = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (model_ptr + k) % NCH;
        if (found < 0 && ch_enable[2'(c)] && head[c] < push_cnt[c]) found = c;
      end
      if (found < 0) break;
      n = 0;
      while (n < BURST && head[found] < push_cnt[found]) begin
        exp_q.push_back({4'hA, 4'(found), mem[found][8'(head[found])]});
        head[found]++;
        n++;
      end
      model_ptr = (found + 1) % NCH;
    end
    model_wc += exp_q.size();
  endtask

  task automatic drain(input string tag, input int mode);
    int quiet;
    int budget;
    quiet  = 0;
    budget = 0;
    while (quiet < 2 && budget < 3000) begin
      cyc(mode);
      budget++;
      if (!busy && ((fifo_data_available & ch_enable) == '0)) quiet++;
      else quiet = 0;
    end
    chk({tag, " drained"}, 32'(quiet >= 2), 32'd1);
    chk({tag, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s word[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hDEAD, exp_q[i]);
    chk({tag, " word_count"}, word_count, 32'(16'(model_wc)));
    chk({tag, " protocol"}, viol, 0);
  endtask

  task automatic do_reset();
    @(negedge SYSCLK);
    RESET = 1'b1;
    repeat (2) @(negedge SYSCLK);
    RESET      = 1'b0;
    prev_stall = 1'b0;
    model_ptr  = 0;
    model_wc   = 0;
  endtask

  initial begin
    int push_cyc;
    int n2;
    int run;
    int max_run;
    int guard;
    logic stable;
    logic rdz;

    ch_enable = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge SYSCLK);
    #1;
    chk("reset read_fifo", read_fifo, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset word_count", word_count, 0);
    @(negedge SYSCLK);
    RESET = 1'b0;

    // Two words on ch0: latency and intra-burst spacing.
    ch_enable = 4'hF;
    cyc(0);
    push(0, 8'h15);
    push(0, 8'h2B);
    push_cyc = cyc_n;
    rd_cyc.delete();
    fv_cyc = -1;
    build_expect();
    drain("ch0 pair", 0);
    chk("ch0 reads", rd_cyc.size(), 2);
    chk("first read latency", (rd_cyc.size() > 0) ? rd_cyc[0] - push_cyc : -1, 1);
    chk("read spacing", (rd_cyc.size() > 1) ? rd_cyc[1] - rd_cyc[0] : -1, 3);
    chk("first valid latency", fv_cyc - push_cyc, 3);

    // One word per channel from a fresh pointer, then a probe of where the pointer ended.
    do_reset();
    for (int i = 0; i < NCH; i++) push(i, 8'(8'h10 + i));
    build_expect();
    drain("one each", 0);
    chk("one each idle", busy, 0);
    push(3, 8'h33);
    push(0, 8'h30);
    build_expect();
    drain("ptr probe", 0);
    chk("ptr probe first", (got.size() > 0) ? got[0] : 32'hDEAD, 32'h0000A030);

    // Burst limit: ch1 x6, ch2 x1.
    for (int j = 0; j < 6; j++) push(1, 8'(8'h60 + j));
    push(2, 8'h70);
    build_expect();
    drain("burst", 0);
    max_run = 0;
    run = 0;
    for (int i = 0; i < got.size(); i++) begin
      run = (i > 0 && got[i][11:8] == got[i-1][11:8]) ? run + 1 : 1;
      if (run > max_run) max_run = run;
    end
    chk("burst max run", max_run, BURST);

    // Downstream stall for 5 cycles while OUTPUT holds a word.
    push(0, 8'h5A);
    build_expect();
    guard = 0;
    while (!out_valid && guard < 20) begin
      cyc(2);
      guard++;
    end
    chk("stall reached output", out_valid, 1);
    stable = 1'b1;
    rdz    = 1'b1;
    repeat (5) begin
      cyc(2);
      if (!(out_valid && out_data == 16'hA05A)) stable = 1'b0;
      if (read_fifo != '0) rdz = 1'b0;
    end
    chk("stall data stable", stable, 1);
    chk("stall no read", rdz, 1);
    chk("stall word_count", word_count, 32'(16'(model_wc - 1)));
    drain("stall", 0);

    // Channel 1 masked off while every channel has data.
    ch_enable = 4'b1101;
    for (int i = 0; i < NCH; i++) begin
      push(i, 8'(8'hB0 + i));
      push(i, 8'(8'hC0 + i));
    end
    rd_n[1] = 0;
    build_expect();
    drain("mask", 1);
    chk("mask ch1 reads", rd_n[1], 0);
    ch_enable = 4'hF;
    build_expect();
    drain("mask release", 1);

    // Mid-burst disable: the word already strobed is delivered, then the grant rotates.
    do_reset();
    for (int j = 0; j < 5; j++) push(2, 8'(8'h80 + j));
    push(3, 8'h90);
    exp_q.delete();
    got.delete();
    exp_q.push_back(16'hA280);
    exp_q.push_back(16'hA281);
    exp_q.push_back(16'hA390);
    model_wc = 3;
    n2 = 0;
    guard = 0;
    while (n2 < 2 && guard < 50) begin
      cyc(0);
      if (read_fifo[2]) n2++;
      guard++;
    end
    ch_enable[2] = 1'b0;
    drain("disable", 0);
    ch_enable = 4'hF;
    exp_q.delete();
    got.delete();
    exp_q.push_back(16'hA282);
    exp_q.push_back(16'hA283);
    exp_q.push_back(16'hA284);
    model_wc  = 6;
    model_ptr = 3;
    drain("re-enable", 0);

    // Asynchronous reset while the first word waits for FIFO data.
    push(0, 8'hC1);
    push(0, 8'hC2);
    push(1, 8'hD1);
    guard = 0;
    while (read_fifo == '0 && guard < 20) begin
      cyc(0);
      guard++;
    end
    @(negedge SYSCLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("async busy", busy, 0);
    chk("async out_valid", out_valid, 0);
    chk("async read_fifo", read_fifo, 0);
    chk("async out_data", out_data, 0);
    chk("async word_count", word_count, 0);
    @(negedge SYSCLK);
    RESET      = 1'b0;
    prev_stall = 1'b0;
    model_ptr  = 0;
    model_wc   = 0;
    build_expect();
    drain("after reset", 0);

    // Randomized fills, masks and backpressure.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NCH; i++) begin
        int n;
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) push(i, 8'($urandom));
      end
      ch_enable = 4'($urandom_range(1, 15));
      build_expect();
      drain($sformatf("rand%0d", t), 1);
    end

    chk("protocol total", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
